// File: rtl/pc_sequencer.sv
// Instruction-fetch PC sequencer.
// Keeps the fetch PC, issues single-cycle instruction-memory requests, and
// holds one fetched instruction in the if_* slot for decode. Redirects from
// CSR (trap/mret) and execute (branch/jump) take priority over sequential
// fetch. A misaligned execute target traps the sequencer in FAULT until a
// CSR redirect arrives.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        csr_redirect,
  input  logic [31:0] csr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        flush,
  output logic        misalign_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Slot contents after reset: an addi x0,x0,0 so a stray read decodes as a NOP.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        misalign_q;
  logic [31:0] fault_addr_q;

  logic        take_ex;
  logic        fetch_ok;
  logic        transfer;
  logic [31:0] csr_pc_d;
  logic [31:0] pc_inc_d;

  // An execute redirect is only honoured outside FAULT; a CSR redirect always wins.
  assign take_ex  = ex_redirect && (state_q != FAULT);

  // Fetch only in FETCH, never in a redirect cycle, and only when the slot is free
  // or being consumed this cycle.
  assign fetch_ok = (state_q == FETCH) && !csr_redirect && !ex_redirect
                    && (!if_valid_q || !stall);

  assign imem_req  = !rst && fetch_ok;
  assign imem_addr = pc_q;
  assign transfer  = imem_req && imem_ack;
  assign flush     = !rst && (csr_redirect || take_ex);

  // CSR targets are forced word-aligned, so a trap/mret can never fault.
  assign csr_pc_d  = csr_target & 32'hFFFF_FFFC;
  assign pc_inc_d  = pc_q + 32'd4;

  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign misalign_fault = misalign_q;
  assign fault_addr     = fault_addr_q;

  // Sequencer FSM: reset, redirect priority, fetch slot and fault capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'h0000_0000;
      if_instr_q   <= NOP_INSTR;
      misalign_q   <= 1'b0;
      fault_addr_q <= 32'h0000_0000;
    end else begin
      misalign_q <= 1'b0;
      if (csr_redirect) begin
        pc_q       <= csr_pc_d;
        state_q    <= FETCH;
        if_valid_q <= 1'b0;
      end else if (take_ex) begin
        pc_q       <= ex_target;
        if_valid_q <= 1'b0;
        if (ex_target[1:0] != 2'b00) begin
          state_q      <= FAULT;
          misalign_q   <= 1'b1;
          fault_addr_q <= ex_target;
        end else begin
          state_q <= FETCH;
        end
      end else begin
        case (state_q)
          BOOT: state_q <= FETCH;
          FETCH: begin
            if (transfer) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_instr_q <= imem_rdata;
              pc_q       <= pc_inc_d;
            end else if (!stall) begin
              if_valid_q <= 1'b0;
            end
          end
          FAULT:   if_valid_q <= 1'b0;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 The block SHALL have port stall, input, 1, decode cannot accept if_* this cycle.
REQ-005 The block SHALL have ports ex_redirect, input, 1, and ex_target, input, 32, for a taken branch/jal/jalr from execute.
REQ-006 The block SHALL have ports csr_redirect, input, 1, and csr_target, input, 32, for a trap entry or mret.
REQ-007 The block SHALL have ports imem_req, output, 1, and imem_addr, output, 32, for the fetch request.
REQ-008 The block SHALL have ports imem_ack, input, 1, and imem_rdata, input, 32; a transfer occurs in a cycle with imem_req && imem_ack, and rdata is valid in that same cycle.
REQ-009 The block SHALL have ports if_valid, output, 1; if_pc, output, 32; and if_instr, output, 32, all registered, forming the fetched-instruction slot.
REQ-010 The block SHALL have port flush, output, 1, combinational, which kills younger instructions in decode/execute.
REQ-011 The block SHALL have ports misalign_fault, output, 1, a registered single-cycle pulse, and fault_addr, output, 32, registered.

Function
REQ-012 The block SHALL keep an internal 32-bit pc register and a state machine with states BOOT, FETCH and FAULT.
REQ-013 In BOOT, imem_req SHALL be 0 and the next state SHALL be FETCH (one bubble cycle after reset).
REQ-014 In FETCH, imem_req SHALL be asserted when no redirect is present and (!if_valid || !stall); imem_addr SHALL equal pc in every state.
REQ-015 On a transfer, the block SHALL set if_valid<=1, if_pc<=pc and if_instr<=imem_rdata, and advance pc by 4, wrapping modulo 2^32.
REQ-016 If if_valid && !stall and no transfer occurs, the block SHALL clear if_valid (slot consumed); if stall=1, all if_* SHALL hold.
REQ-017 Redirect priority SHALL be rst > csr_redirect > ex_redirect > sequential pc+4.
REQ-018 flush SHALL equal csr_redirect || ex_redirect in BOOT/FETCH, and csr_redirect alone in FAULT.
REQ-019 In a redirect cycle, the block SHALL force imem_req=0 (no transfer), clear if_valid at the next edge, and load pc with the winning target.
REQ-020 For a CSR redirect, the block SHALL load pc <= {csr_target[31:2],2'b00}, enter FETCH from any state, and never fault.
REQ-021 For an ex_redirect with ex_target[1:0]!=0, the block SHALL pulse misalign_fault, set fault_addr<=ex_target, set pc<=ex_target, and enter FAULT.
REQ-022 In FAULT, imem_req SHALL be 0, if_valid SHALL be 0, and ex_redirect SHALL be ignored; only csr_redirect or rst exits FAULT.
REQ-023 A stall SHALL NOT delay a redirect; a redirect overrides stall in the same cycle.
REQ-024 misalign_fault SHALL be high for exactly one cycle per faulting redirect; fault_addr SHALL hold until the next fault or rst.

Reset
REQ-025 While rst=1, the block SHALL set state=BOOT, pc=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013, misalign_fault=0 and fault_addr=0.
REQ-026 While rst=1, imem_req and flush SHALL be 0.
REQ-027 A concurrent imem_ack or redirect SHALL be discarded when rst=1, including reset asserted mid-operation.

Verification
REQ-028 Release rst with imem_ack=1 and stall=0 -> BOOT cycle with imem_req=0, then imem_addr 0x0,0x4,0x8 on consecutive cycles, and if_pc 0x0,0x4 valid one cycle after each transfer.
REQ-029 Hold stall=1 for 3 cycles with if_valid=1 and if_pc=0x8 -> imem_req=0 and if_pc/if_instr stable, then the next transfer is at 0xC after stall drops.
REQ-030 Assert ex_redirect with ex_target=0x100 while imem_ack=1 -> flush=1 and imem_req=0 that cycle, if_valid=0 next cycle, then imem_addr=0x100.
REQ-031 Assert csr_redirect (0x80) and ex_redirect (0x200) simultaneously -> next imem_addr=0x80, and 0x200 is never fetched.
REQ-032 Assert ex_redirect with ex_target=0x102 -> misalign_fault one-cycle pulse, fault_addr=0x102, imem_req=0 until csr_redirect 0x40, then fetch 0x40.
REQ-033 Assert rst in a cycle with imem_ack=1 and ex_redirect=1 -> no if update, pc=RESET_PC, if_valid=0, then a BOOT bubble follows.
